// File: rtl/eth_arb_pkg.sv
// Shared types and constants for the Ethernet TX packet arbiter.
package eth_arb_pkg;

  localparam int unsigned STATE_W  = 2;
  localparam int unsigned STREAK_W = 8;

  typedef logic [STATE_W-1:0] arb_state_t;

  localparam arb_state_t IDLE     = 2'd0;
  localparam arb_state_t GNT_CHDR = 2'd1;
  localparam arb_state_t GNT_CPU  = 2'd2;

  localparam int unsigned GNT_CHDR_BIT = 0;
  localparam int unsigned GNT_CPU_BIT  = 1;

  // A weight of zero still lets one CHDR packet through before the CPU turn.
  function automatic logic [STREAK_W-1:0] eff_weight(input logic [STREAK_W-1:0] w);
    return (w == '0) ? STREAK_W'(1) : w;
  endfunction

endpackage

// File: rtl/pkt_counter.sv
// Wrapping packet counter; a clear wins over a same-cycle increment.
module pkt_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/eth_tx_pkt_arbiter.sv
// Packet-atomic CHDR/CPU arbiter in front of the MAC TX stream.
// CHDR is weighted; CPU gets a packet after cfg_chdr_weight back-to-back CHDR packets.
module eth_tx_pkt_arbiter
  import eth_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned USER_W = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              bus_clk,
  input  logic              bus_rst_n,
  input  logic              tx_en,
  input  logic [7:0]        cfg_chdr_weight,
  input  logic              cnt_clr,
  input  logic [DATA_W-1:0] s_chdr_tdata,
  input  logic [USER_W-1:0] s_chdr_tuser,
  input  logic              s_chdr_tlast,
  input  logic              s_chdr_tvalid,
  output logic              s_chdr_tready,
  input  logic [DATA_W-1:0] s_cpu_tdata,
  input  logic [USER_W-1:0] s_cpu_tuser,
  input  logic              s_cpu_tlast,
  input  logic              s_cpu_tvalid,
  output logic              s_cpu_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [USER_W-1:0] m_tuser,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  chdr_pkt_count,
  output logic [CNT_W-1:0]  cpu_pkt_count
);

  arb_state_t          state;
  arb_state_t          state_nxt;
  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streak_nxt;
  logic                chdr_done;
  logic                cpu_done;

  assign chdr_done = (state == GNT_CHDR) && s_chdr_tvalid && m_tready && s_chdr_tlast;
  assign cpu_done  = (state == GNT_CPU)  && s_cpu_tvalid  && m_tready && s_cpu_tlast;

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
    end
  end

  // Decisions only happen in IDLE, so a grant is held for the whole packet.
  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    case (state)
      IDLE: begin
        if (tx_en) begin
          if (s_chdr_tvalid && (!s_cpu_tvalid || (streak < eff_weight(cfg_chdr_weight)))) begin
            state_nxt = GNT_CHDR;
            if (!s_cpu_tvalid) begin
              streak_nxt = '0;
            end else if (streak != '1) begin
              streak_nxt = streak + STREAK_W'(1);
            end
          end else if (s_cpu_tvalid) begin
            state_nxt  = GNT_CPU;
            streak_nxt = '0;
          end
        end
      end
      GNT_CHDR: if (chdr_done) state_nxt = IDLE;
      GNT_CPU:  if (cpu_done)  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Zero-latency pass-through of the granted source; the idle path is quiet.
  always_comb begin
    m_tdata       = '0;
    m_tuser       = '0;
    m_tlast       = 1'b0;
    m_tvalid      = 1'b0;
    s_chdr_tready = 1'b0;
    s_cpu_tready  = 1'b0;
    grant         = '0;
    case (state)
      GNT_CHDR: begin
        m_tdata             = s_chdr_tdata;
        m_tuser             = s_chdr_tuser;
        m_tlast             = s_chdr_tlast;
        m_tvalid            = s_chdr_tvalid;
        s_chdr_tready       = m_tready;
        grant[GNT_CHDR_BIT] = 1'b1;
      end
      GNT_CPU: begin
        m_tdata            = s_cpu_tdata;
        m_tuser            = s_cpu_tuser;
        m_tlast            = s_cpu_tlast;
        m_tvalid           = s_cpu_tvalid;
        s_cpu_tready       = m_tready;
        grant[GNT_CPU_BIT] = 1'b1;
      end
      default: ;
    endcase
  end

  pkt_counter #(.CNT_W(CNT_W)) u_chdr_cnt (
    .clk   (bus_clk),
    .rst_n (bus_rst_n),
    .clr   (cnt_clr),
    .inc   (chdr_done),
    .count (chdr_pkt_count)
  );

  pkt_counter #(.CNT_W(CNT_W)) u_cpu_cnt (
    .clk   (bus_clk),
    .rst_n (bus_rst_n),
    .clr   (cnt_clr),
    .inc   (cpu_done),
    .count (cpu_pkt_count)
  );

endmodule

// File: doc/eth_tx_pkt_arbiter.md
Name: eth_tx_pkt_arbiter

Overview:
- Packet-atomic arbiter that shares the single Ethernet MAC TX stream between the CHDR egress path (v2e) and the CPU egress path (c2e).
- It sits between the two egress FIFOs of the IPv4 adapter and eth_tx.
- CHDR gets weighted priority. CPU traffic is guaranteed one packet after every cfg_chdr_weight consecutive CHDR packets.
- Provides a TX enable, per-source packet counters and a grant indication for debug registers.

Parameters:
- DATA_W, 64, tdata width of all streams (ENET_W).
- USER_W, 4, tuser width; passed through unmodified (trailing bytes / error).
- CNT_W, 32, width of the packet counters.

Ports:
- bus_clk  in  1  Clock for all logic.
- bus_rst_n  in  1  Asynchronous, active-low reset.
- tx_en  in  1  Enable. When low, no new packet is granted; the current packet completes.
- cfg_chdr_weight  in  8  Max consecutive CHDR packets while CPU waits. 0 is treated as 1.
- cnt_clr  in  1  Synchronous clear of both packet counters.
- s_chdr_tdata/tuser/tlast/tvalid  in  DATA_W/USER_W/1/1  CHDR source stream.
- s_chdr_tready  out  1  CHDR source ready.
- s_cpu_tdata/tuser/tlast/tvalid  in  DATA_W/USER_W/1/1  CPU source stream.
- s_cpu_tready  out  1  CPU source ready.
- m_tdata/tuser/tlast/tvalid  out  DATA_W/USER_W/1/1  Stream to MAC.
- m_tready  in  1  MAC ready.
- grant  out  2  One-hot current grant: {cpu, chdr}; 0 when IDLE.
- chdr_pkt_count  out  CNT_W  CHDR packets forwarded.
- cpu_pkt_count  out  CNT_W  CPU packets forwarded.

Behaviour:
- Reset (bus_rst_n low, asynchronous):
  - State enters IDLE.
  - grant=0, both s_*_tready=0, m_tvalid=0.
  - Counters=0, streak=0.
- FSM states are IDLE, GNT_CHDR and GNT_CPU, registered.
- IDLE: no handshakes occur (all treadies 0, m_tvalid 0). If tx_en is high, the next state is chosen as follows:
  - Both tvalid high and streak < max(weight,1) → GNT_CHDR.
  - Both tvalid high and streak ≥ max(weight,1) → GNT_CPU.
  - Only CHDR tvalid high → GNT_CHDR.
  - Only CPU tvalid high → GNT_CPU.
  - Otherwise stay in IDLE.
- GNT_x data path:
  - Combinational pass-through with 0-cycle latency: m_* = s_x_*, s_x_tready = m_tready.
  - The other source's tready is 0.
- Leaving GNT_x: on s_x_tvalid & m_tready & s_x_tlast, return to IDLE. Packets are therefore separated by exactly one idle cycle; minimum arbitration cost is 1 cycle/packet.
- Grant is never changed mid-packet, regardless of tx_en, cfg changes or the other source.
- Streak counter, 8 bits, saturating at 255:
  - Increments when entering GNT_CHDR while CPU tvalid is high.
  - Cleared when entering GNT_CHDR while CPU tvalid is low.
  - Cleared when entering GNT_CPU.
- Packet counters:
  - The source counter increments on each tlast handshake and wraps modulo 2^CNT_W.
  - cnt_clr takes priority over a same-cycle increment; the result is 0.
- cfg_chdr_weight is sampled only in IDLE; a change takes effect at the next decision.
- tx_en low mid-packet: the packet finishes, then the FSM stays in IDLE until tx_en is high again.
- Zero-length stall: if the granted source drops tvalid mid-packet, the arbiter waits indefinitely (no timeout).
- AXI-stream rules:
  - m_tvalid must not depend on m_tready.
  - Once m_tvalid is high, payload is held stable by the source's own AXI compliance, since the grant is fixed.

Decomposition:
- Package eth_arb_pkg:
  - enum arb_state_t {IDLE, GNT_CHDR, GNT_CPU}.
  - Grant bit indices GNT_CHDR_BIT=0, GNT_CPU_BIT=1.
- No sub-module needed.
- Optional: the two counters may share one small sub-module, pkt_counter (CNT_W, clr priority, wrap).

Test Plan:
- Reset mid-packet: assert bus_rst_n=0 during a CHDR packet → grant=0, m_tvalid=0 and counters=0 immediately (asynchronous). After release the FSM restarts in IDLE.
- Weighted sharing: weight=3, both sources continuously valid with 4-beat packets → output order CHDR,CHDR,CHDR,CPU repeating; after 8 packets chdr_pkt_count=6 and cpu_pkt_count=2.
- Weight 0 and single source: weight=0 with both valid → strict alternation CHDR,CPU,…. CPU only, 10 packets → cpu_pkt_count=10 with one idle cycle between packets.
- Backpressure atomicity: m_tready toggled at random during a 6-beat CPU packet while CHDR is valid → all 6 CPU beats are contiguous, s_chdr_tready=0 throughout, and tdata/tuser match the source beat-for-beat.
- tx_en drop: deassert on beat 2 of a 5-beat packet → all 5 beats sent, then no grant while tx_en=0. Re-assert → the next packet is granted after 1 cycle.
- Counters: preload by sending 2^CNT_W−1 packets (CNT_W=4 build, i.e. 15) then send one more → count=0 (wrap). Assert cnt_clr on the same cycle as a tlast handshake → count=0.
